// File: rtl/if_fetch_ctrl_if.sv
// Instruction-side SRAM-like bus: one request/address handshake plus a data-return strobe.
// The fetch sequencer is the master; the memory side is the slave.
interface if_fetch_ctrl_if;
  logic        inst_req;
  logic [31:0] inst_addr;
  logic        inst_addr_ok;
  logic        inst_data_ok;
  logic [31:0] inst_rdata;

  modport master (
    output inst_req,
    output inst_addr,
    input  inst_addr_ok,
    input  inst_data_ok,
    input  inst_rdata
  );

  modport slave (
    input  inst_req,
    input  inst_addr,
    output inst_addr_ok,
    output inst_data_ok,
    output inst_rdata
  );
endinterface

// File: rtl/if_fetch_ctrl.sv
// Instruction-fetch sequencer: owns the fetch PC, keeps one request in flight,
// applies eret/exception/branch redirects and discards responses they make stale.
module if_fetch_ctrl #(
  parameter logic [31:0] RESET_ADDR = 32'hbfc0_0000,
  parameter logic [31:0] EXC_ADDR   = 32'hbfc0_0380
) (
  input  logic                   clk,
  input  logic                   resetn,
  input  logic                   stall,
  input  logic                   eret,
  input  logic [31:0]            epc,
  input  logic                   exc_oc,
  input  logic                   br_take,
  input  logic [31:0]            br_target,
  if_fetch_ctrl_if.master        ibus,
  output logic                   if_valid,
  output logic [31:0]            if_pc,
  output logic [31:0]            if_inst
);

  typedef enum logic [1:0] {IDLE, REQ, WAIT, HOLD} state_e;

  state_e      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic        cancel_q, cancel_d;
  logic        if_valid_q, if_valid_d;
  logic [31:0] if_pc_q, if_pc_d;
  logic [31:0] if_inst_q, if_inst_d;

  logic        redir;
  logic [31:0] redir_tgt;

  // Only the highest-priority redirect of the cycle takes effect.
  always_comb begin
    redir     = eret | exc_oc | br_take;
    redir_tgt = br_target;
    if (eret) begin
      redir_tgt = epc;
    end else if (exc_oc) begin
      redir_tgt = EXC_ADDR;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q    <= IDLE;
      pc_q       <= RESET_ADDR;
      cancel_q   <= 1'b0;
      if_valid_q <= 1'b0;
      if_pc_q    <= 32'h0;
      if_inst_q  <= 32'h0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      cancel_q   <= cancel_d;
      if_valid_q <= if_valid_d;
      if_pc_q    <= if_pc_d;
      if_inst_q  <= if_inst_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    cancel_d   = cancel_q;
    if_valid_d = 1'b0;
    if_pc_d    = if_pc_q;
    if_inst_d  = if_inst_q;

    unique case (state_q)
      IDLE: begin
        state_d = REQ;
      end

      REQ: begin
        // A redirect cancels this issue; if the bus accepted it anyway the
        // response must still be drained in WAIT and thrown away.
        if (redir) begin
          pc_d = redir_tgt;
          if (ibus.inst_addr_ok) begin
            state_d  = WAIT;
            cancel_d = 1'b1;
          end
        end else if (ibus.inst_addr_ok) begin
          state_d  = WAIT;
          cancel_d = 1'b0;
        end
      end

      WAIT: begin
        if (ibus.inst_data_ok) begin
          if (cancel_q || redir) begin
            if (redir) begin
              pc_d = redir_tgt;
            end
            cancel_d = 1'b0;
            state_d  = REQ;
          end else begin
            if_valid_d = 1'b1;
            if_pc_d    = pc_q;
            if_inst_d  = ibus.inst_rdata;
            pc_d       = pc_q + 32'd4;
            state_d    = stall ? HOLD : REQ;
          end
        end else if (redir) begin
          pc_d     = redir_tgt;
          cancel_d = 1'b1;
        end
      end

      HOLD: begin
        if (redir) begin
          pc_d    = redir_tgt;
          state_d = REQ;
        end else if (!stall) begin
          state_d = REQ;
        end else begin
          if_valid_d = 1'b1;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign ibus.inst_req  = (state_q == REQ);
  assign ibus.inst_addr = pc_q;
  assign if_valid       = if_valid_q;
  assign if_pc          = if_pc_q;
  assign if_inst        = if_inst_q;

endmodule

// File: tb/tb_if_fetch_ctrl.sv
// Bench for if_fetch_ctrl: directed scenarios plus a randomized run against a
// transaction-level model of the fetch rules with a random-latency memory slave.
module tb_if_fetch_ctrl;
  localparam logic [31:0] RST_PC = 32'hbfc0_0000;
  localparam logic [31:0] EXC_PC = 32'hbfc0_0380;

  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic        stall, eret, exc_oc, br_take;
  logic [31:0] epc, br_target;
  logic        if_valid;
  logic [31:0] if_pc, if_inst;

  int total = 0;
  int bad   = 0;

  if_fetch_ctrl_if ibus ();

  if_fetch_ctrl #(.RESET_ADDR(RST_PC), .EXC_ADDR(EXC_PC)) dut (
    .clk(clk), .resetn(resetn), .stall(stall), .eret(eret), .epc(epc),
    .exc_oc(exc_oc), .br_take(br_take), .br_target(br_target), .ibus(ibus),
    .if_valid(if_valid), .if_pc(if_pc), .if_inst(if_inst)
  );

  always #5 clk = ~clk;

  // Reference model: fetch pc, whether a request is in flight, whether its
  // answer is already doomed, and what decode currently sees.
  logic [31:0] m_pc, m_ppc, m_pinst;
  logic        m_busy, m_stale, m_held, m_show;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    stall = 0; eret = 0; exc_oc = 0; br_take = 0; epc = 0; br_target = 0;
    ibus.inst_addr_ok = 0; ibus.inst_data_ok = 0; ibus.inst_rdata = 0;
  endtask

  // Leaves the DUT in its first requesting cycle at RST_PC.
  task automatic do_reset();
    clear_inputs();
    resetn = 0;
    tick(); tick();
    resetn = 1;
    tick();
    m_pc = RST_PC; m_ppc = 0; m_pinst = 0;
    m_busy = 0; m_stale = 0; m_held = 0; m_show = 0;
  endtask

  task automatic model_step(input logic rd, input logic [31:0] tgt, input logic aok,
                            input logic dok, input logic [31:0] rdata, input logic stl);
    if (m_held) begin
      if (rd) m_pc = tgt;
      if (rd || !stl) begin m_held = 0; m_show = 0; end
    end else if (!m_busy) begin
      m_show = 0;
      if (aok) begin m_busy = 1; m_stale = rd; end
      if (rd) m_pc = tgt;
    end else begin
      m_show = 0;
      if (dok) begin
        if (m_stale || rd) begin
          if (rd) m_pc = tgt;
        end else begin
          m_show = 1; m_ppc = m_pc; m_pinst = rdata; m_pc = m_pc + 32'd4; m_held = stl;
        end
        m_busy = 0; m_stale = 0;
      end else if (rd) begin
        m_pc = tgt; m_stale = 1;
      end
    end
  endtask

  function automatic logic [31:0] pick_target();
    logic [31:0] r;
    r = $urandom();
    if ($urandom_range(0, 3) == 0) return 32'hffff_fffc;
    return r & 32'hffff_fffc;
  endfunction

  task automatic test_reset();
    clear_inputs();
    resetn = 0;
    tick();
    total++; if (ibus.inst_req !== 1'b0) begin bad++; $display("FAIL reset_req got=%0h want=0", ibus.inst_req); end
    total++; if (ibus.inst_addr !== RST_PC) begin bad++; $display("FAIL reset_addr got=%08h want=%08h", ibus.inst_addr, RST_PC); end
    total++; if (if_valid !== 1'b0) begin bad++; $display("FAIL reset_valid got=%0h want=0", if_valid); end
    total++; if (if_pc !== 32'h0 || if_inst !== 32'h0) begin bad++; $display("FAIL reset_ifregs got pc=%08h inst=%08h want 0/0", if_pc, if_inst); end
    resetn = 1;
    total++; if (ibus.inst_req !== 1'b0) begin bad++; $display("FAIL idle_req got=%0h want=0", ibus.inst_req); end
    tick();
    total++; if (ibus.inst_req !== 1'b1 || ibus.inst_addr !== RST_PC) begin bad++; $display("FAIL first_req got req=%0h addr=%08h want 1/%08h", ibus.inst_req, ibus.inst_addr, RST_PC); end
    $display("test_reset: first request at %08h", ibus.inst_addr);
  endtask

  task automatic test_stream();
    logic [31:0] a, d;
    do_reset();
    for (int k = 0; k < 3; k++) begin
      a = RST_PC + 32'(4 * k);
      d = 32'h1000_0000 + 32'(k);
      total++; if (ibus.inst_req !== 1'b1 || ibus.inst_addr !== a) begin bad++; $display("FAIL stream_req%0d got req=%0h addr=%08h want 1/%08h", k, ibus.inst_req, ibus.inst_addr, a); end
      ibus.inst_addr_ok = 1;
      tick();
      ibus.inst_addr_ok = 0;
      total++; if (ibus.inst_req !== 1'b0) begin bad++; $display("FAIL stream_wait%0d got req=%0h want=0", k, ibus.inst_req); end
      ibus.inst_data_ok = 1; ibus.inst_rdata = d;
      tick();
      ibus.inst_data_ok = 0;
      total++; if (if_valid !== 1'b1 || if_pc !== a || if_inst !== d) begin bad++; $display("FAIL stream_out%0d got v=%0h pc=%08h inst=%08h want 1/%08h/%08h", k, if_valid, if_pc, if_inst, a, d); end
      $display("test_stream: fetched pc=%08h inst=%08h", if_pc, if_inst);
    end
  endtask

  task automatic test_branch_in_wait();
    ibus.inst_addr_ok = 1;
    tick();
    ibus.inst_addr_ok = 0;
    br_take = 1; br_target = 32'h8000_1000;
    tick();
    br_take = 0;
    ibus.inst_data_ok = 1; ibus.inst_rdata = 32'hdead_beef;
    tick();
    ibus.inst_data_ok = 0;
    total++; if (if_valid !== 1'b0) begin bad++; $display("FAIL br_wait_valid got=%0h want=0", if_valid); end
    total++; if (ibus.inst_req !== 1'b1 || ibus.inst_addr !== 32'h8000_1000) begin bad++; $display("FAIL br_wait_addr got req=%0h addr=%08h want 1/80001000", ibus.inst_req, ibus.inst_addr); end
    $display("test_branch_in_wait: next addr=%08h", ibus.inst_addr);
  endtask

  task automatic test_priority();
    eret = 1; epc = 32'h8000_0200; exc_oc = 1; br_take = 1; br_target = 32'h8000_5000;
    tick();
    eret = 0; exc_oc = 0; br_take = 0;
    total++; if (ibus.inst_req !== 1'b1 || ibus.inst_addr !== 32'h8000_0200) begin bad++; $display("FAIL priority_addr got req=%0h addr=%08h want 1/80000200", ibus.inst_req, ibus.inst_addr); end
    $display("test_priority: next addr=%08h", ibus.inst_addr);
  endtask

  task automatic test_stall();
    ibus.inst_addr_ok = 1;
    tick();
    ibus.inst_addr_ok = 0;
    ibus.inst_data_ok = 1; ibus.inst_rdata = 32'h2401_0001; stall = 1;
    tick();
    ibus.inst_data_ok = 0;
    for (int c = 0; c < 3; c++) begin
      total++; if (if_valid !== 1'b1 || if_inst !== 32'h2401_0001 || if_pc !== 32'h8000_0200 || ibus.inst_req !== 1'b0) begin bad++; $display("FAIL stall_hold%0d got v=%0h pc=%08h inst=%08h req=%0h want 1/80000200/24010001/0", c, if_valid, if_pc, if_inst, ibus.inst_req); end
      if (c == 2) stall = 0;
      tick();
    end
    total++; if (if_valid !== 1'b0 || ibus.inst_req !== 1'b1 || ibus.inst_addr !== 32'h8000_0204) begin bad++; $display("FAIL stall_release got v=%0h req=%0h addr=%08h want 0/1/80000204", if_valid, ibus.inst_req, ibus.inst_addr); end
    $display("test_stall: released, next addr=%08h", ibus.inst_addr);
  endtask

  task automatic test_exc_in_hold();
    ibus.inst_addr_ok = 1;
    tick();
    ibus.inst_addr_ok = 0;
    ibus.inst_data_ok = 1; ibus.inst_rdata = 32'h0000_0021; stall = 1;
    tick();
    ibus.inst_data_ok = 0;
    total++; if (if_valid !== 1'b1) begin bad++; $display("FAIL exc_hold_pre got v=%0h want=1", if_valid); end
    exc_oc = 1;
    tick();
    exc_oc = 0; stall = 0;
    total++; if (if_valid !== 1'b0 || ibus.inst_req !== 1'b1 || ibus.inst_addr !== EXC_PC) begin bad++; $display("FAIL exc_hold got v=%0h req=%0h addr=%08h want 0/1/%08h", if_valid, ibus.inst_req, ibus.inst_addr, EXC_PC); end
    $display("test_exc_in_hold: next addr=%08h", ibus.inst_addr);
  endtask

  task automatic test_reset_mid();
    ibus.inst_addr_ok = 1;
    tick();
    ibus.inst_addr_ok = 0;
    resetn = 0;
    #1;
    total++; if (ibus.inst_req !== 1'b0 || ibus.inst_addr !== RST_PC || if_valid !== 1'b0) begin bad++; $display("FAIL midreset_async got req=%0h addr=%08h v=%0h want 0/%08h/0", ibus.inst_req, ibus.inst_addr, if_valid, RST_PC); end
    tick();
    resetn = 1;
    ibus.inst_data_ok = 1; ibus.inst_rdata = 32'h1234_5678;
    for (int c = 0; c < 2; c++) begin
      tick();
      total++; if (ibus.inst_req !== 1'b1 || ibus.inst_addr !== RST_PC || if_valid !== 1'b0) begin bad++; $display("FAIL midreset_late%0d got req=%0h addr=%08h v=%0h want 1/%08h/0", c, ibus.inst_req, ibus.inst_addr, if_valid, RST_PC); end
    end
    ibus.inst_data_ok = 0;
    $display("test_reset_mid: restarted at %08h", ibus.inst_addr);
  endtask

  task automatic test_random();
    logic        s_pend, rd, dok;
    int          s_lat, errs_before;
    logic [31:0] tgt;
    do_reset();
    s_pend = 0; s_lat = 0;
    errs_before = bad;
    for (int n = 0; n < 3000; n++) begin
      stall   = ($urandom_range(0, 9) < 3);
      eret    = ($urandom_range(0, 19) == 0);
      exc_oc  = ($urandom_range(0, 19) == 0);
      br_take = ($urandom_range(0, 9) == 0);
      epc = pick_target(); br_target = pick_target();
      ibus.inst_addr_ok = $urandom_range(0, 1);
      dok = s_pend && (s_lat == 0);
      ibus.inst_data_ok = dok;
      ibus.inst_rdata = $urandom();
      rd  = eret | exc_oc | br_take;
      tgt = eret ? epc : (exc_oc ? EXC_PC : br_target);
      total++; if (ibus.inst_req !== (!m_busy && !m_held) || ibus.inst_addr !== m_pc) begin bad++; $display("FAIL rnd_bus cyc=%0d got req=%0h addr=%08h want %0h/%08h", n, ibus.inst_req, ibus.inst_addr, !m_busy && !m_held, m_pc); end
      total++; if (if_valid !== m_show || if_pc !== m_ppc || if_inst !== m_pinst) begin bad++; $display("FAIL rnd_dec cyc=%0d got v=%0h pc=%08h inst=%08h want %0h/%08h/%08h", n, if_valid, if_pc, if_inst, m_show, m_ppc, m_pinst); end
      if (dok) s_pend = 0;
      else if (s_pend) s_lat--;
      if (ibus.inst_req && ibus.inst_addr_ok) begin s_pend = 1; s_lat = $urandom_range(0, 2); end
      model_step(rd, tgt, ibus.inst_addr_ok, dok, ibus.inst_rdata, stall);
      tick();
    end
    clear_inputs();
    $display("test_random: 3000 cycles, %0d new errors", bad - errs_before);
  endtask

  initial begin
    clear_inputs();
    test_reset();
    test_stream();
    test_branch_in_wait();
    test_priority();
    test_stall();
    test_exc_in_hold();
    test_reset_mid();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/if_fetch_ctrl.md
# if_fetch_ctrl

Instruction-fetch sequencer sitting between the PC logic and the instruction-side SRAM-like bus of the core. It owns the fetch PC and issues one request at a time. It applies redirects (eret, exception, taken branch) at any point in a fetch, and discards responses made stale by a redirect. It presents each fetched instruction to decode with a valid flag that holds under pipeline stall.

## Interface
Parameters:
- RESET_ADDR, 32'hbfc0_0000, fetch PC after reset
- EXC_ADDR, 32'hbfc0_0380, exception entry PC

Ports:
- clk  in  1  clock; all state updates on rising edge
- resetn  in  1  asynchronous, active-low reset
- stall  in  1  1: decode cannot accept the presented instruction
- eret  in  1  redirect to epc (highest priority)
- epc  in  32  eret target
- exc_oc  in  1  redirect to EXC_ADDR
- br_take  in  1  redirect to br_target (lowest priority)
- br_target  in  32  branch target
- inst_req  out  1  fetch request valid
- inst_addr  out  32  fetch address, equals internal pc
- inst_addr_ok  in  1  request accepted this cycle
- inst_data_ok  in  1  response data valid this cycle
- inst_rdata  in  32  response data
- if_valid  out  1  if_pc/if_inst valid for decode
- if_pc  out  32  PC of presented instruction
- if_inst  out  32  presented instruction

## Operation
- States: IDLE, REQ, WAIT, HOLD. At most one request is outstanding.
- Redirect: the cycle's redirect is eret ? epc : exc_oc ? EXC_ADDR : br_take ? br_target : none. When several are asserted, only the highest applies.
- IDLE: unconditionally goes to REQ on the next cycle. inst_req=0.
- REQ: inst_req=1, inst_addr=pc.
  - With a redirect: pc loads the target and the state stays REQ. The issue is treated as cancelled, even if inst_addr_ok=1 that cycle, so the accepted old address goes to WAIT with cancel=1.
  - Otherwise, inst_addr_ok=1 goes to WAIT with cancel=0.
- WAIT: inst_req=0.
  - A redirect loads pc with the target and sets cancel=1. A later redirect overwrites pc again.
  - On inst_data_ok with cancel=1, or with a redirect in the same cycle: drop the data, clear cancel, go to REQ with the current pc.
  - On inst_data_ok otherwise: capture if_pc=pc and if_inst=inst_rdata, assert if_valid, and set pc=pc+4.
    - If stall=0, go to REQ.
    - If stall=1, go to HOLD.
- HOLD: if_valid=1 and the outputs stay frozen.
  - A redirect drops if_valid, loads pc with the target, and goes to REQ.
  - stall=0 drops if_valid and goes to REQ.
- PC arithmetic is 32-bit modulo. 32'hffff_fffc+4 wraps to 0. No alignment check is done.
- Reset mid-operation: outputs return to reset values immediately. Any outstanding response arriving after reset release is ignored, because the state is IDLE/REQ and data_ok outside WAIT is ignored.

## Timing
- Reset values: inst_req=0, inst_addr=RESET_ADDR, if_valid=0, if_pc=0, if_inst=0, cancel=0, state=IDLE.
- First request: inst_req=1 with RESET_ADDR in the second cycle after resetn rises.
- inst_req and inst_addr are decoded from registers only; there is no combinational path from any input.
- if_valid, if_pc and if_inst are registered. A response in cycle N gives if_valid=1 in cycle N+1.
- The captured instruction is presented for one cycle when stall is low at capture. After that one cycle, if_valid drops.
- Best case: request accepted in cycle N, data_ok in cycle N+1, next request in cycle N+2. That gives one instruction per 2 cycles.
- A redirect in the cycle data_ok would be presented still suppresses it: if_valid stays 0.

## Test plan
- Reset, then addr_ok in the same cycle as each req and data_ok 1 cycle later -> inst_addr sequence bfc00000, bfc00004, bfc00008. if_pc matches, with a 2-cycle period.
- br_take=1, br_target=80001000 in WAIT, then data_ok -> no if_valid for the old instruction; next inst_addr=80001000.
- eret=1 (epc=80000200), exc_oc=1 and br_take=1 in the same REQ cycle -> next inst_addr=80000200.
- stall=1 when data_ok arrives with inst_rdata=24010001 -> if_valid=1 and if_inst=24010001 held 3 cycles until stall drops. Next request is pc+4.
- exc_oc in HOLD -> if_valid drops the next cycle; inst_addr=bfc00380.
- Pulse resetn low while in WAIT, then a late data_ok after release -> ignored; fetch restarts at bfc00000.
